// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite animation block: mode encodings,
// state-word bit positions, default parameter values and small helpers.
package sprite_pkg;

  typedef enum logic [1:0] {
    MODE_STAND = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_JUMP  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // Bit positions inside the 3-bit state word
  localparam int ST_DIR      = 0;
  localparam int ST_MODE_LSB = 1;
  localparam int ST_MODE_MSB = 2;

  // Default parameter values
  localparam int          DEF_W        = 47;
  localparam int          DEF_H        = 48;
  localparam int          DEF_PW       = 12;
  localparam int          DEF_TICK_DIV = 6000000;
  localparam int          DEF_HOLD     = 4;
  localparam int          DEF_N_STAND  = 4;
  localparam int          DEF_N_RUN    = 4;
  localparam int          DEF_N_JUMP   = 1;
  localparam logic [11:0] DEF_KEY      = 12'h000;

  // clog2 that never returns 0, so single-value counters still get one bit
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The reserved mode animates exactly like stand
  function automatic mode_e eff_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_STAND : mode_e'(m);
  endfunction

endpackage

// File: rtl/anim_ticker.sv
// Animation timebase: prescaler -> tick, hold counter per frame, and the
// frame counter that wraps at the frame count of the current mode.
module anim_ticker
  import sprite_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int HOLD     = DEF_HOLD,
  parameter int N_STAND  = DEF_N_STAND,
  parameter int N_RUN    = DEF_N_RUN,
  parameter int N_JUMP   = DEF_N_JUMP,
  localparam int FW      = clog2_min1(max3(N_STAND, N_RUN, N_JUMP))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  output logic [FW-1:0] frame_idx
);

  localparam int PSW = clog2_min1(TICK_DIV);
  localparam int HW  = clog2_min1(HOLD);

  logic [PSW-1:0] ps;
  logic [HW-1:0]  hold_cnt;
  logic [1:0]     mode_q;
  logic           tick;
  logic           mode_chg;
  logic [FW-1:0]  last_frame;

  // Tick strobe, mode-change detect and last frame index of the current mode
  always_comb begin
    tick     = en && (ps == PSW'(TICK_DIV - 1));
    mode_chg = (mode != mode_q);
    case (eff_mode(mode))
      MODE_RUN:  last_frame = FW'(N_RUN - 1);
      MODE_JUMP: last_frame = FW'(N_JUMP - 1);
      default:   last_frame = FW'(N_STAND - 1);
    endcase
  end

  // Prescaler freezes while paused and is never cleared by a mode change
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ps <= '0;
    else if (en)
      ps <= tick ? '0 : ps + 1'b1;
  end

  // Previous-cycle mode, used to detect a mode change
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mode_q <= 2'b00;
    else
      mode_q <= mode;
  end

  // Hold and frame counters; a mode change wins over a coincident tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      frame_idx <= '0;
    end else if (mode_chg) begin
      hold_cnt  <= '0;
      frame_idx <= '0;
    end else if (tick) begin
      if (hold_cnt == HW'(HOLD - 1)) begin
        hold_cnt  <= '0;
        frame_idx <= (frame_idx == last_frame) ? '0 : frame_idx + 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_anim.sv
// Sprite animation top: mirrors pixel requests into frame-local ROM
// addresses and returns pixels through a fixed 3-edge pipeline around a
// synchronous ROM.
module sprite_anim
  import sprite_pkg::*;
#(
  parameter int          W        = DEF_W,
  parameter int          H        = DEF_H,
  parameter int          PW       = DEF_PW,
  parameter int          TICK_DIV = DEF_TICK_DIV,
  parameter int          HOLD     = DEF_HOLD,
  parameter int          N_STAND  = DEF_N_STAND,
  parameter int          N_RUN    = DEF_N_RUN,
  parameter int          N_JUMP   = DEF_N_JUMP,
  parameter logic [PW-1:0] KEY    = PW'(DEF_KEY),
  localparam int CW = clog2_min1(W),
  localparam int RW = clog2_min1(H),
  localparam int AW = clog2_min1(W * H),
  localparam int FW = clog2_min1(max3(N_STAND, N_RUN, N_JUMP))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    state,
  input  logic          pix_req,
  input  logic [CW-1:0] pix_col,
  input  logic [RW-1:0] pix_row,
  output logic [1:0]    rom_mode,
  output logic [FW-1:0] rom_frame,
  output logic [AW-1:0] rom_addr,
  input  logic [PW-1:0] rom_data,
  output logic [PW-1:0] pix_out,
  output logic          pix_valid,
  output logic          pix_transp,
  output logic [FW-1:0] frame_idx
);

  logic          dir;
  logic [1:0]    mode_raw;
  logic          oor_c;
  logic [AW-1:0] col_m;
  logic [AW-1:0] addr_c;
  logic          vld_p1, oor_p1;
  logic          vld_p2, oor_p2;

  assign dir      = state[ST_DIR];
  assign mode_raw = state[ST_MODE_MSB:ST_MODE_LSB];

  anim_ticker #(
    .TICK_DIV (TICK_DIV),
    .HOLD     (HOLD),
    .N_STAND  (N_STAND),
    .N_RUN    (N_RUN),
    .N_JUMP   (N_JUMP)
  ) u_ticker (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode_raw),
    .frame_idx (frame_idx)
  );

  // Range check and mirrored address; the extra bit keeps W/H comparable
  // even when they are an exact power of two
  always_comb begin
    oor_c  = ({1'b0, pix_col} >= (CW+1)'(W)) || ({1'b0, pix_row} >= (RW+1)'(H));
    col_m  = dir ? AW'(pix_col) : AW'(W - 1) - AW'(pix_col);
    addr_c = oor_c ? '0 : AW'(pix_row) * AW'(W) + col_m;
  end

  // Stage 1: capture address, bank and frame on the request edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      oor_p1    <= 1'b0;
      rom_addr  <= '0;
      rom_mode  <= 2'b00;
      rom_frame <= '0;
    end else begin
      vld_p1 <= pix_req;
      if (pix_req) begin
        oor_p1    <= oor_c;
        rom_addr  <= addr_c;
        rom_mode  <= eff_mode(mode_raw);
        rom_frame <= frame_idx;
      end
    end
  end

  // Stage 2: wait out the ROM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      oor_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      oor_p2 <= oor_p1;
    end
  end

  // Stage 3: present the pixel; idle and out-of-range slots drive zero data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid  <= 1'b0;
      pix_out    <= '0;
      pix_transp <= 1'b0;
    end else begin
      pix_valid  <= vld_p2;
      pix_out    <= (vld_p2 && !oor_p2) ? rom_data : '0;
      pix_transp <= vld_p2 && (oor_p2 || (rom_data == KEY));
    end
  end

endmodule

// File: tb/tb_sprite_anim.sv
// Bench for sprite_anim: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_sprite_anim;

  localparam int          W    = 47;
  localparam int          H    = 48;
  localparam int          TD   = 4;
  localparam int          HOLD = 2;
  localparam int          NS   = 4;
  localparam int          NR   = 4;
  localparam int          NJ   = 1;
  localparam logic [11:0] KEY  = 12'h000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  state = 3'b000;
  logic        pix_req = 1'b0;
  logic [5:0]  pix_col = '0;
  logic [5:0]  pix_row = '0;
  logic [1:0]  rom_mode;
  logic [1:0]  rom_frame;
  logic [11:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic [11:0] pix_out;
  logic        pix_valid;
  logic        pix_transp;
  logic [1:0]  frame_idx;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sprite_anim #(
    .W(W), .H(H), .PW(12), .TICK_DIV(TD), .HOLD(HOLD),
    .N_STAND(NS), .N_RUN(NR), .N_JUMP(NJ), .KEY(KEY)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .state(state), .pix_req(pix_req),
    .pix_col(pix_col), .pix_row(pix_row), .rom_mode(rom_mode),
    .rom_frame(rom_frame), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_out(pix_out), .pix_valid(pix_valid), .pix_transp(pix_transp),
    .frame_idx(frame_idx)
  );

  // Synthetic sprite ROM contents; some addresses hold the key colour
  function automatic logic [11:0] rom_f(input int m, input int f, input int a);
    if (a % 50 == 3) return KEY;
    return 12'((a * 13 + f * 517 + m * 1031 + 1) % 4096);
  endfunction

  function automatic int nof(input int m);
    case (m)
      1: return NR;
      2: return NJ;
      default: return NS;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) rom_data <= rom_f(int'(rom_mode), int'(rom_frame), int'(rom_addr));

  // ---------------- behavioural model ----------------
  typedef struct { bit v; bit oor; int data; } ent_t;
  ent_t s1 = '{1'b0, 1'b0, 0};
  ent_t s2 = '{1'b0, 1'b0, 0};
  ent_t oq = '{1'b0, 1'b0, 0};
  ent_t nw;
  int   en_cnt = 0;     // enabled clocks since reset
  int   ticks = 0;      // ticks since the last mode change
  int   prev_mode = 0;
  int   m_fidx = 0;
  int   m_addr = 0, m_mode = 0, m_frame = 0;
  int   c_i, r_i, md, a_i;
  bit   tk, oor_i;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 = '{1'b0, 1'b0, 0}; s2 = '{1'b0, 1'b0, 0}; oq = '{1'b0, 1'b0, 0};
      en_cnt = 0; ticks = 0; prev_mode = 0; m_fidx = 0;
      m_addr = 0; m_mode = 0; m_frame = 0;
    end else begin
      md = int'(state[2:1]);
      nw = '{1'b0, 1'b0, 0};
      if (pix_req) begin
        c_i = int'(pix_col); r_i = int'(pix_row);
        oor_i = (c_i >= W) || (r_i >= H);
        a_i = oor_i ? 0 : r_i * W + (state[0] ? c_i : W - 1 - c_i);
        m_addr = a_i; m_mode = (md == 3) ? 0 : md; m_frame = m_fidx;
        nw = '{1'b1, oor_i, int'(rom_f(m_mode, m_fidx, a_i))};
      end
      oq = s2; s2 = s1; s1 = nw;
      tk = en && ((en_cnt % TD) == TD - 1);
      if (en) en_cnt++;
      if (md != prev_mode) ticks = 0;
      else if (tk) ticks++;
      prev_mode = md;
      m_fidx = (ticks / HOLD) % nof(md);
    end
  end

  // Compare every cycle away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("frame_idx", int'(frame_idx), m_fidx);
      chk("rom_addr", int'(rom_addr), m_addr);
      chk("rom_mode", int'(rom_mode), m_mode);
      chk("rom_frame", int'(rom_frame), m_frame);
      chk("pix_valid", int'(pix_valid), int'(oq.v));
      chk("pix_out", int'(pix_out), (oq.v && !oq.oor) ? oq.data : 0);
      chk("pix_transp", int'(pix_transp),
          int'(oq.v && (oq.oor || oq.data == int'(KEY))));
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] seen [0:40];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_frame"}, int'(frame_idx), 0);
    chk({tag, "_addr"}, int'(rom_addr), 0);
    chk({tag, "_rmode"}, int'(rom_mode), 0);
    chk({tag, "_rframe"}, int'(rom_frame), 0);
    chk({tag, "_out"}, int'(pix_out), 0);
    chk({tag, "_valid"}, int'(pix_valid), 0);
    chk({tag, "_transp"}, int'(pix_transp), 0);
  endtask

  task automatic do_reset(input logic [2:0] st);
    rst = 1'b1; en = 1'b1; state = st; pix_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic request(input logic [2:0] st, input int col, input int row);
    state = st; pix_col = 6'(col); pix_row = 6'(row); pix_req = 1'b1;
    step();
    pix_req = 1'b0;
  endtask

  initial begin
    // Run-mode frame sequence from reset
    rst = 1'b1; en = 1'b1; state = 3'b011;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); #1;
    rst = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      step();
      seen[n] = frame_idx;
    end
    chk("seq_e7", int'(seen[7]), 0);
    chk("seq_e8", int'(seen[8]), 1);
    chk("seq_e15", int'(seen[15]), 1);
    chk("seq_e16", int'(seen[16]), 2);
    chk("seq_e24", int'(seen[24]), 3);
    chk("seq_e31", int'(seen[31]), 3);
    chk("seq_e32", int'(seen[32]), 0);
    chk("seq_e40", int'(seen[40]), 1);

    // Mirrored addressing and 3-edge latency
    request(3'b010, 0, 1);
    chk("addr_dir0", int'(rom_addr), 93);
    chk("lat_e1", int'(pix_valid), 0);
    step(); chk("lat_e2", int'(pix_valid), 0);
    step(); chk("lat_e3", int'(pix_valid), 1);
    step(); chk("lat_e4", int'(pix_valid), 0);
    request(3'b011, 0, 1);
    chk("addr_dir1", int'(rom_addr), 47);
    step(); step();
    chk("lat_dir1", int'(pix_valid), 1);

    // Out-of-range column and key-colour pixel
    request(3'b011, 47, 0);
    step(); step();
    chk("oor_valid", int'(pix_valid), 1);
    chk("oor_transp", int'(pix_transp), 1);
    chk("oor_out", int'(pix_out), 0);
    request(3'b011, 3, 0);
    chk("key_addr", int'(rom_addr), 3);
    step(); step();
    chk("key_valid", int'(pix_valid), 1);
    chk("key_transp", int'(pix_transp), 1);
    request(3'b010, 10, 48);
    step(); step();
    chk("oor_row_transp", int'(pix_transp), 1);

    // run -> jump coinciding with the frame-advancing tick at frame 2
    do_reset(3'b011);
    for (int n = 1; n <= 23; n++) step();
    chk("pre_jump_frame", int'(frame_idx), 2);
    state = 3'b101;
    step();
    chk("jump_frame", int'(frame_idx), 0);
    for (int n = 0; n < 8; n++) step();
    chk("jump_stays", int'(frame_idx), 0);
    state = 3'b011;
    for (int n = 0; n < 12; n++) step();

    // Reset with two requests in flight, then pause
    do_reset(3'b011);
    step();
    pix_col = 6'd5; pix_row = 6'd5; pix_req = 1'b1;
    step(); step();
    pix_req = 1'b0;
    rst = 1'b1;
    #2;
    chk_all_zero("inflight");
    @(negedge clk); #1;
    rst = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      step();
      chk("post_rst_valid", int'(pix_valid), 0);
    end
    for (int n = 6; n <= 10; n++) step();
    chk("pause_before", int'(frame_idx), 1);
    en = 1'b0;
    for (int n = 11; n <= 30; n++) step();
    chk("pause_end", int'(frame_idx), 1);
    en = 1'b1;
    for (int n = 31; n <= 35; n++) step();
    chk("resume_e35", int'(frame_idx), 1);
    step();
    chk("resume_e36", int'(frame_idx), 2);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) state[2:1] = 2'($urandom_range(0, 3));
      state[0] = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 7) != 0);
      pix_req = ($urandom_range(0, 2) != 0);
      pix_col = 6'($urandom_range(0, 50));
      pix_row = 6'($urandom_range(0, 50));
      if (i == 400) begin
        rst = 1'b1;
        #3;
        rst = 1'b0;
      end
      step();
    end
    pix_req = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_anim.md
SPRITE_ANIM -- requirements
Module: sprite_anim

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- W, 47, sprite width in pixels.
- H, 48, sprite height in pixels.
- PW, 12, pixel width (RGB444).
- TICK_DIV, 6000000, clocks per animation tick.
- HOLD, 4, ticks each frame is held.
- N_STAND, 4, stand frame count.
- N_RUN, 4, run frame count.
- N_JUMP, 1, jump frame count.
- KEY, 12'h000, transparent colour.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- en, in, 1, animation enable; low = pause.
- state, in, 3; [0] dir, 1=right; [2:1] mode, 00 stand, 01 run, 10 jump, 11 reserved.
- pix_req, in, 1, pixel request strobe.
- pix_col, in, clog2(W), column.
- pix_row, in, clog2(H), row.
- rom_mode, out, 2, ROM bank select.
- rom_frame, out, clog2(max N), ROM frame select.
- rom_addr, out, clog2(W*H), frame-local ROM address.
- rom_data, in, PW, synchronous ROM output, 1-cycle latency.
- pix_out, out, PW, pixel.
- pix_valid, out, 1, pix_out valid.
- pix_transp, out, 1, pixel is transparent.
- frame_idx, out, clog2(max N), current frame.

Function
REQ-003 Prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and pulse tick for one clock at TICK_DIV-1; it SHALL hold its value while en=0.
REQ-004 Hold counter SHALL count 0..HOLD-1 on tick; on tick at HOLD-1 it SHALL wrap to 0 and advance frame_idx modulo N of the current mode.
REQ-005 Mode 11 SHALL be treated as stand (N_STAND, rom_mode=00).
REQ-006 A change in state[2:1] between consecutive clocks SHALL clear frame_idx and the hold counter on the next edge, overriding a coincident tick; the prescaler SHALL NOT be cleared.
REQ-007 A change in state[0] alone SHALL NOT alter frame_idx or the counters.
REQ-008 Stage 1, on the edge sampling pix_req=1, SHALL register rom_addr = row*W + col if dir=1, or row*W + (W-1-col) if dir=0, together with rom_mode and rom_frame from the same cycle.
REQ-009 If col>=W or row>=H, rom_addr SHALL be 0 and the request SHALL be flagged out-of-range.
REQ-010 pix_out, pix_valid and pix_transp SHALL update on the 3rd rising edge counting the edge that sampled pix_req.
REQ-011 Latency SHALL be fixed; back-to-back requests SHALL give one result per clock.
REQ-012 pix_transp SHALL be 1 if rom_data==KEY or the request was out-of-range; an out-of-range request SHALL output pix_out=0.
REQ-013 pix_valid SHALL be 0 in any cycle with no request in stage 3.
REQ-014 Address arithmetic SHALL be unsigned and sized to clog2(W*H); W-1-col SHALL never underflow for in-range col.

Reset
REQ-015 rst SHALL asynchronously clear the prescaler, hold counter, frame_idx, rom_addr, rom_mode, rom_frame, pix_out, pix_valid, pix_transp and all pipeline valids to 0.
REQ-016 Requests in flight at reset SHALL be discarded, with no pix_valid after reset deasserts.
REQ-017 After reset deassertion, the first tick SHALL occur TICK_DIV clocks later with en=1.

Structure
REQ-018 Mode encodings, state bit positions and default parameter values SHALL live in shared package sprite_pkg.
REQ-019 The prescaler, hold counter and frame counter SHALL be one sub-module, anim_ticker; address mirroring and the output pipeline SHALL stay in sprite_anim.

Verification (TICK_DIV=4, HOLD=2, N_RUN=4, W=47, H=48)
REQ-020 Run mode, en=1, 40 clocks -> frame_idx sequence 0,1,2,3,0 with each frame held 8 clocks.
REQ-021 dir=0, col=0, row=1, pix_req -> rom_addr=93; dir=1 -> rom_addr=47; pix_valid is 1 exactly 3 edges after the sampling edge.
REQ-022 Mode change run->jump on the same clock as a frame-advancing tick at frame 2 -> frame_idx=0 and hold=0 next edge; it stays 0.
REQ-023 col=47 request -> pix_valid=1, pix_transp=1, pix_out=0; rom_data=KEY in range -> pix_transp=1.
REQ-024 rst pulsed with 2 requests in flight -> all outputs 0, no pix_valid afterwards; en=0 for 20 clocks freezes frame_idx and the prescaler.
